// File: rtl/mem_stall_ctrl_if.sv
// mem_stall_ctrl_if: EX/MEM-side inputs, data-memory handshake and stall outputs of the MEM-stage sequencer
interface mem_stall_ctrl_if #(parameter int STALL_CNT_W = 32);
  logic                   MemRead_i;
  logic                   MemWrite_i;
  logic [31:0]            addr_i;
  logic [31:0]            data_i;
  logic                   mem_req_o;
  logic                   mem_we_o;
  logic [31:0]            mem_addr_o;
  logic [31:0]            mem_data_o;
  logic                   mem_ack_i;
  logic [31:0]            mem_rdata_i;
  logic [31:0]            rdata_o;
  logic                   stall_o;
  logic [STALL_CNT_W-1:0] stall_cnt_o;
  modport slave (
    input  MemRead_i, MemWrite_i, addr_i, data_i, mem_ack_i, mem_rdata_i,
    output mem_req_o, mem_we_o, mem_addr_o, mem_data_o, rdata_o, stall_o, stall_cnt_o
  );
  modport master (
    output MemRead_i, MemWrite_i, addr_i, data_i, mem_ack_i, mem_rdata_i,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_data_o, rdata_o, stall_o, stall_cnt_o
  );
endinterface

// File: rtl/mem_stall_ctrl.sv
// mem_stall_ctrl: MEM-stage data-memory sequencer; freezes the pipeline during a req/ack access and counts stall cycles
module mem_stall_ctrl #(
  parameter int STALL_CNT_W = 32
) (
  input logic               clk_i,
  input logic               rst_i,
  mem_stall_ctrl_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t                 state_q, state_d;
  logic                   we_q;
  logic [31:0]            addr_q, data_q, rdata_q;
  logic [STALL_CNT_W-1:0] cnt_q;
  logic                   access, req, stall;
  assign access = bus.MemRead_i | bus.MemWrite_i;
  always_ff @(posedge clk_i) begin
    state_q <= rst_i ? IDLE : state_d;
  end
  // DONE always returns to IDLE: EX/MEM still holds the finished instruction there
  always_comb begin
    state_d = state_q == IDLE ? (access ? BUSY : IDLE) :
              state_q == BUSY ? (bus.mem_ack_i ? DONE : BUSY) : IDLE;
  end
  always_comb begin
    req   = state_q == BUSY;
    stall = !rst_i && (req || (state_q == IDLE && access));
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      if (state_q == IDLE && access) begin
        we_q   <= bus.MemWrite_i;
        addr_q <= bus.addr_i;
        data_q <= bus.data_i;
      end
      if (req && bus.mem_ack_i && !we_q) rdata_q <= bus.mem_rdata_i;
      if (stall && !(&cnt_q)) cnt_q <= cnt_q + 1'b1;
    end
  end
  assign bus.mem_req_o   = req;
  assign bus.mem_we_o    = we_q;
  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_data_o  = data_q;
  assign bus.rdata_o     = rdata_q;
  assign bus.stall_o     = stall;
  assign bus.stall_cnt_o = cnt_q;
endmodule

// File: tb/tb_mem_stall_ctrl.sv
// tb_mem_stall_ctrl: scoreboard bench; stimulus queues expected accesses, a monitor checks each completed access
module tb_mem_stall_ctrl;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;
  mem_stall_ctrl_if #(.STALL_CNT_W(32)) bus ();
  mem_stall_ctrl_if #(.STALL_CNT_W(3))  bus3 ();
  mem_stall_ctrl #(.STALL_CNT_W(32)) dut  (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));
  mem_stall_ctrl #(.STALL_CNT_W(3))  dut3 (.clk_i(clk_i), .rst_i(rst_i), .bus(bus3));
  typedef struct {int k; logic [31:0] rdata;} rsp_t;
  typedef struct {logic we; logic [31:0] addr; logic [31:0] data; int k; logic [31:0] rdata; longint cnt;} exp_t;
  rsp_t        mem_q[$];
  exp_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic        ack_r = 1'b0, spur_ack = 1'b0, mon_en = 1'b1;
  logic [31:0] rdata_r = '0;
  logic [31:0] model_rdata = '0;
  longint      model_cnt = 0;
  assign bus.mem_ack_i    = ack_r | spur_ack;
  assign bus.mem_rdata_i  = spur_ack ? 32'hFFFF_FFFF : rdata_r;
  assign bus3.MemRead_i   = bus.MemRead_i;
  assign bus3.MemWrite_i  = bus.MemWrite_i;
  assign bus3.addr_i      = bus.addr_i;
  assign bus3.data_i      = bus.data_i;
  assign bus3.mem_ack_i   = bus.mem_ack_i;
  assign bus3.mem_rdata_i = bus.mem_rdata_i;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask
  // memory responder: acks on the k-th cycle the request is seen, garbage on rdata otherwise
  always @(negedge clk_i) begin
    static int c = 0;
    static rsp_t cur = '{1, 32'h0};
    ack_r = 1'b0;
    rdata_r = $urandom;
    if (bus.mem_req_o) begin
      if (c == 0) cur = mem_q.size() > 0 ? mem_q.pop_front() : '{1, 32'h0};
      c++;
      if (c == cur.k) begin
        ack_r = 1'b1;
        rdata_r = cur.rdata;
      end
    end else c = 0;
  end
  // monitor: compares each request and each completed access against the scoreboard
  always @(negedge clk_i) begin
    static int run = 0, rq = 0;
    exp_t e;
    if (mon_en && !rst_i) begin
      if (bus.mem_req_o) begin
        rq++;
        if (exp_q.size() == 0) chk("req_without_expect", 1, 0);
        else begin
          chk("mem_we", bus.mem_we_o, exp_q[0].we);
          chk("mem_addr", bus.mem_addr_o, exp_q[0].addr);
          chk("mem_data", bus.mem_data_o, exp_q[0].data);
        end
      end
      if (bus.stall_o) run++;
      else if (run > 0) begin
        if (exp_q.size() == 0) chk("done_without_expect", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("stall_cycles", run, e.k + 1);
          chk("req_cycles", rq, e.k);
          chk("req_in_done", bus.mem_req_o, 0);
          chk("rdata", bus.rdata_o, e.rdata);
          chk("stall_cnt", bus.stall_cnt_o, e.cnt > 64'hFFFF_FFFF ? 64'hFFFF_FFFF : e.cnt);
          chk("stall_cnt_w3", bus3.stall_cnt_o, e.cnt > 7 ? 7 : e.cnt);
        end
        run = 0;
        rq = 0;
      end
    end else begin
      run = 0;
      rq = 0;
    end
  end
  task automatic do_access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                           input int k, input logic [31:0] rdv);
    int t = 0;
    if (!wr) model_rdata = rdv;
    model_cnt += k + 1;
    mem_q.push_back('{k, rdv});
    exp_q.push_back('{wr, a, d, k, model_rdata, model_cnt});
    bus.MemRead_i  = rd;
    bus.MemWrite_i = wr;
    bus.addr_i     = a;
    bus.data_i     = d;
    do begin
      @(negedge clk_i);
      t++;
    end while (bus.stall_o && t < 100);
    if (t >= 100) chk("access_timeout", 1, 0);
    @(posedge clk_i) #1;
    bus.MemRead_i  = 1'b0;
    bus.MemWrite_i = 1'b0;
    bus.addr_i     = $urandom;
    bus.data_i     = $urandom;
  endtask
  initial begin
    bus.MemRead_i  = 1'b1;
    bus.MemWrite_i = 1'b0;
    bus.addr_i     = 32'h44;
    bus.data_i     = 32'h0;
    repeat (2) begin
      @(negedge clk_i);
      chk("stall_in_reset", bus.stall_o, 0);
    end
    @(posedge clk_i) #1;
    rst_i = 1'b0;
    bus.MemRead_i = 1'b0;
    @(negedge clk_i);
    chk("rst_req", bus.mem_req_o, 0);
    chk("rst_we", bus.mem_we_o, 0);
    chk("rst_addr", bus.mem_addr_o, 0);
    chk("rst_data", bus.mem_data_o, 0);
    chk("rst_rdata", bus.rdata_o, 0);
    chk("rst_cnt", bus.stall_cnt_o, 0);
    @(posedge clk_i) #1;
    do_access(1, 0, 32'h40, 32'h0, 3, 32'hDEAD_BEEF);
    do_access(0, 1, 32'h80, 32'h1234_5678, 1, 32'h5555_5555);
    do_access(1, 0, 32'h100, 32'h0, 1, 32'hCAFE_F00D);
    do_access(0, 1, 32'h104, 32'hA5A5_A5A5, 1, 32'h0);
    do_access(1, 1, 32'h108, 32'h0BAD_0BAD, 2, 32'h7777_7777);
    spur_ack = 1'b1;
    @(posedge clk_i) #1;
    spur_ack = 1'b0;
    @(negedge clk_i);
    chk("spur_req", bus.mem_req_o, 0);
    chk("spur_stall", bus.stall_o, 0);
    chk("spur_rdata", bus.rdata_o, model_rdata);
    @(posedge clk_i) #1;
    mon_en = 1'b0;
    mem_q.push_back('{20, 32'hFFFF_FFFF});
    bus.MemRead_i = 1'b1;
    bus.addr_i    = 32'h200;
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    bus.MemRead_i = 1'b0;
    @(posedge clk_i) #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("abort_req", bus.mem_req_o, 0);
    spur_ack = 1'b1;
    @(posedge clk_i) #1;
    spur_ack = 1'b0;
    @(negedge clk_i);
    chk("late_ack_req", bus.mem_req_o, 0);
    chk("late_ack_stall", bus.stall_o, 0);
    chk("late_ack_rdata", bus.rdata_o, 0);
    chk("late_ack_cnt", bus.stall_cnt_o, 0);
    exp_q.delete();
    mem_q.delete();
    model_rdata = '0;
    model_cnt = 0;
    @(posedge clk_i) #1;
    mon_en = 1'b1;
    repeat (3) do_access(1, 0, $urandom, $urandom, 3, $urandom);
    chk("sat_w3", bus3.stall_cnt_o, 7);
    repeat (40) begin
      bit rd, wr;
      wr = $urandom_range(0, 2) == 0;
      rd = !wr || ($urandom_range(0, 3) == 0);
      do_access(rd, wr, $urandom, $urandom, $urandom_range(1, 6), $urandom);
      repeat ($urandom_range(0, 2)) @(posedge clk_i);
      #1;
    end
    repeat (2) @(posedge clk_i);
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("final_w3_sat", bus3.stall_cnt_o, 7);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_stall_ctrl.md
# mem_stall_ctrl

Data-memory access sequencer for the 5-stage pipeline's MEM stage. It watches the MemRead/MemWrite control bits and address/write data held in the EX/MEM pipeline register and runs a multi-cycle request/acknowledge transaction to the data memory. It freezes the pipeline until the access completes and presents load data to MEM/WB. It also keeps a saturating count of stall cycles for performance measurement.

## Interface
- STALL_CNT_W, 32, width of the stall-cycle counter
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  synchronous, active-high reset
- MemRead_i  in  1  load in MEM stage (EX/MEM M bit)
- MemWrite_i  in  1  store in MEM stage (EX/MEM M bit)
- addr_i  in  32  access address (EX/MEM ALU result)
- data_i  in  32  store data (EX/MEM)
- mem_req_o  out  1  request to data memory
- mem_we_o  out  1  1 = write, 0 = read; valid while mem_req_o
- mem_addr_o  out  32  latched address; valid while mem_req_o
- mem_data_o  out  32  latched store data; valid while mem_req_o
- mem_ack_i  in  1  memory completion, single-cycle pulse
- mem_rdata_i  in  32  read data, valid with mem_ack_i
- rdata_o  out  32  load data to MEM/WB
- stall_o  out  1  hold PC, IF/ID, ID/EX, EX/MEM
- stall_cnt_o  out  STALL_CNT_W  cycles with stall_o = 1

## Operation
- States: IDLE, BUSY, DONE. Reset state IDLE.
- IDLE:
  - If MemRead_i | MemWrite_i: latch addr_i, data_i and we = MemWrite_i into internal registers; go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - mem_req_o = 1; mem_we_o, mem_addr_o, mem_data_o come from the latched registers and stay stable.
  - On mem_ack_i: capture mem_rdata_i into rdata_o (reads only; writes leave rdata_o unchanged); go to DONE.
- DONE:
  - mem_req_o = 0, stall_o = 0. The pipeline advances at the end of this cycle and MEM/WB captures rdata_o.
  - EX/MEM still holds the completed instruction, so no new access is issued. Go to IDLE.
- stall_o (combinational):
  - 1 in IDLE when MemRead_i | MemWrite_i.
  - 1 throughout BUSY.
  - 0 in DONE, in IDLE with no access, and whenever rst_i = 1.
- MemRead_i and MemWrite_i both high: treated as a write (mem_we_o = 1).
- mem_ack_i outside BUSY is ignored.
- stall_cnt_o: +1 on each clock edge where stall_o = 1; saturates at all-ones, no wrap.

## Timing
- Reset values (edge with rst_i = 1):
  - state IDLE
  - mem_req_o = 0, mem_we_o = 0, mem_addr_o = 0, mem_data_o = 0
  - rdata_o = 0, stall_cnt_o = 0
- Reset mid-BUSY: request is abandoned; mem_req_o = 0 from the next cycle. A late ack after reset is ignored.
- mem_req_o is registered: it rises one cycle after an access appears in IDLE and falls the cycle after mem_ack_i.
- Access with ack after k BUSY cycles (k ≥ 1):
  - occupies k + 2 cycles (IDLE detect, k BUSY, DONE)
  - stall_o high for k + 1 cycles
- Minimum access (ack in first BUSY cycle): 3 cycles, 2 stall cycles.
- Back-to-back memory instructions: DONE → IDLE → new access is detected in that IDLE cycle, with no extra bubble beyond the sequence above.
- rdata_o holds its value until the next read ack.

## Test plan
- Reset: assert rst_i for 2 cycles with MemRead_i = 1 → stall_o = 0, mem_req_o = 0, stall_cnt_o = 0, rdata_o = 0.
- Load, ack on 3rd BUSY cycle, addr 0x0000_0040, mem_rdata_i 0xDEAD_BEEF:
  - mem_req_o high for 3 cycles with mem_we_o = 0 and mem_addr_o = 0x40
  - stall_o high for 4 cycles
  - rdata_o = 0xDEAD_BEEF in DONE
  - stall_cnt_o = 4
- Store, addr 0x80, data 0x1234_5678, ack in first BUSY cycle:
  - mem_we_o = 1, mem_data_o = 0x1234_5678
  - stall_o high 2 cycles
  - rdata_o unchanged
- Back-to-back load then store, each acked after 1 BUSY cycle → 6 cycles total, two distinct requests, no duplicate re-issue in DONE.
- Spurious mem_ack_i in IDLE, with 0xFFFF_FFFF on mem_rdata_i → no state change, rdata_o unchanged. Then rst_i mid-BUSY → mem_req_o = 0 next cycle and the following ack is ignored.
- Counter saturation with STALL_CNT_W = 3: run 3 loads of 4 stall cycles each → stall_cnt_o sticks at 7.
